dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the scalar pipeline and a vector burst unit.
// Scalar wins unless a vector burst has already been passed over once (prio).
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_req,
    input  logic          s_we,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_wdata,
    output logic [DW-1:0] s_rdata,
    output logic          s_stall,
    input  logic          v_req,
    input  logic          v_we,
    input  logic [AW-1:0] v_base,
    input  logic [CW-1:0] v_count,
    input  logic [DW-1:0] v_wdata,
    output logic          v_ack,
    output logic [DW-1:0] v_rdata,
    output logic          v_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // state  | meaning
    // IDLE   | arbitrate scalar vs. new vector burst
    // VBURST | one vector beat per cycle, scalar stalled
    // VDONE  | burst-complete pulse, scalar may still be served
    typedef enum logic [1:0] {IDLE, VBURST, VDONE} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic          s_grant;
    logic          v_accept;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        s_grant   = 1'b0;
        v_accept  = 1'b0;
        mem_addr  = s_addr;
        mem_we    = 1'b0;
        mem_wdata = s_wdata;
        s_stall   = s_req;
        v_ack     = 1'b0;
        v_done    = 1'b0;

        case (state_q)
            IDLE: begin
                s_grant  = s_req && (!v_req || !prio_q);
                v_accept = v_req && !s_grant;
                if (s_grant) begin
                    mem_we  = s_we;
                    s_stall = 1'b0;
                    if (v_req) prio_d = 1'b1;
                end else if (v_accept) begin
                    addr_d  = v_base;
                    we_d    = v_we;
                    cnt_d   = v_count;
                    state_d = (v_count == '0) ? VDONE : VBURST;
                end
            end
            VBURST: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = v_wdata;
                v_ack     = 1'b1;
                addr_d    = addr_q + AW'(4);
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = VDONE;
            end
            VDONE: begin
                s_grant = s_req;
                if (s_grant) begin
                    mem_we  = s_we;
                    s_stall = 1'b0;
                end
                v_done  = 1'b1;
                prio_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must silence the memory port even mid-burst.
        if (!reset) begin
            mem_we  = 1'b0;
            v_ack   = 1'b0;
            v_done  = 1'b0;
            s_stall = 1'b0;
        end
    end

    // Busy covers the acceptance cycle too, so a burst of N beats reads busy for N+2 cycles.
    assign busy    = reset && ((state_q != IDLE) || v_accept);
    assign s_rdata = mem_rdata;
    assign v_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

endmodule
